// File: rtl/cache_defs.sv
// cache_defs: shared boot-memory arbiter types and defaults
`ifndef XLEN
`define XLEN 32
`endif
package cache_defs;
  typedef enum logic [1:0] {IDLE, I_PEND, D_PEND} type_bmem_arb_state_e;
  localparam int BMEM_MAX_D_STREAK = 4;
endpackage

// File: rtl/bmem_arb_prio.sv
// bmem_arb_prio: dbus-first priority that yields to ibus once the dbus streak saturates
module bmem_arb_prio
  import cache_defs::*;
#(
  parameter int MAX_D_STREAK = BMEM_MAX_D_STREAK,
  parameter int SW           = $clog2(MAX_D_STREAK + 1)
) (
  input  logic          i_elig_i,
  input  logic          d_elig_i,
  input  logic [SW-1:0] d_streak_i,
  output logic          grant_i_o,
  output logic          grant_d_o
);
  logic at_max;
  assign at_max    = d_streak_i == SW'(MAX_D_STREAK);
  assign grant_d_o = d_elig_i && !(i_elig_i && at_max);
  assign grant_i_o = i_elig_i && !grant_d_o;
endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one single-cycle boot memory between ibus and dbus readers;
// a grant issued this cycle is acknowledged with the memory data next cycle.
module bmem_arbiter
  import cache_defs::*;
#(
  parameter int MAX_D_STREAK = BMEM_MAX_D_STREAK,
  parameter int ADDR_W       = `XLEN,
  parameter int DATA_W       = `XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  type_bmem_arb_state_e state_q, state_d;
  logic [SW-1:0] d_streak_q, d_streak_d;
  logic i_elig, d_elig, grant_i, grant_d;
  assign i_ack_o   = state_q == I_PEND;
  assign d_ack_o   = state_q == D_PEND;
  assign i_rdata_o = i_ack_o ? mem_rdata_i : '0;
  assign d_rdata_o = d_ack_o ? mem_rdata_i : '0;
  // rst_n gating keeps the strobe low while reset is held, not just after the next edge
  assign i_elig = rst_n && i_req_i && !i_ack_o;
  assign d_elig = rst_n && d_req_i && !d_ack_o;
  bmem_arb_prio #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .SW          (SW)
  ) u_prio (
    .i_elig_i  (i_elig),
    .d_elig_i  (d_elig),
    .d_streak_i(d_streak_q),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d)
  );
  assign mem_req_o  = grant_i || grant_d;
  assign mem_addr_o = grant_i ? i_addr_i : grant_d ? d_addr_i : '0;
  always_comb begin
    state_d    = grant_i ? I_PEND : grant_d ? D_PEND : IDLE;
    d_streak_d = (!i_req_i || grant_i) ? '0 :
                 (grant_d && d_streak_q != SW'(MAX_D_STREAK)) ? d_streak_q + 1'b1 : d_streak_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
    end
  end
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: directed and random checks of bmem_arbiter against a cycle-level reference model
module tb_bmem_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req_i = 1'b0, d_req_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0, d_addr_i = '0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic i_ack_o, d_ack_o, mem_req_o;
  logic [DW-1:0] i_rdata_o, d_rdata_o;
  logic [AW-1:0] mem_addr_o;
  int total = 0, passed = 0;
  int pend = 0, streak = 0, n_req = 0, n_ack = 0, i_wait = 0, max_wait = 0;
  bit ia, da, ie, de, gi, gd;

  bmem_arbiter #(.MAX_D_STREAK(MAXS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // expected outputs for the current cycle, computed from owner/streak bookkeeping
  task automatic eval_check();
    #1;
    ia = pend == 1;
    da = pend == 2;
    ie = i_req_i && !ia;
    de = d_req_i && !da;
    gd = de && !(ie && streak == MAXS);
    gi = ie && !gd;
    chk("i_ack", i_ack_o, ia);
    chk("d_ack", d_ack_o, da);
    chk("i_rdata", i_rdata_o, ia ? mem_rdata_i : '0);
    chk("d_rdata", d_rdata_o, da ? mem_rdata_i : '0);
    chk("mem_req", mem_req_o, gi || gd);
    chk("mem_addr", mem_addr_o, gi ? i_addr_i : gd ? d_addr_i : '0);
    n_req += int'(mem_req_o);
    n_ack += int'(i_ack_o) + int'(d_ack_o);
    if (ie && gd) i_wait++;
    if (gi || !i_req_i) i_wait = 0;
    if (i_wait > max_wait) max_wait = i_wait;
  endtask

  task automatic tick();
    @(posedge clk);
    pend = gi ? 1 : gd ? 2 : 0;
    if (!i_req_i || gi) streak = 0;
    else if (gd && streak < MAXS) streak++;
    @(negedge clk);
  endtask

  task automatic cyc(input bit ir, input logic [AW-1:0] iad, input bit dr, input logic [AW-1:0] dad);
    i_req_i = ir; i_addr_i = iad; d_req_i = dr; d_addr_i = dad;
    mem_rdata_i = $urandom;
    eval_check();
  endtask

  initial begin
    #1;
    chk("rst_i_ack", i_ack_o, 1'b0);
    chk("rst_d_ack", d_ack_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // single ibus read, granted in the first cycle after release
    cyc(1, 32'h1000, 0, 0);
    chk("ib_c0_addr", mem_addr_o, 32'h1000);
    tick();
    cyc(1, 32'h1000, 0, 0);
    chk("ib_c1_data", i_rdata_o, mem_rdata_i);
    tick();
    // simultaneous requests: dbus first, ibus next
    cyc(1, 32'h1000, 1, 32'h2000);
    chk("sim_c0_addr", mem_addr_o, 32'h2000);
    tick();
    cyc(1, 32'h1000, 1, 32'h2000);
    chk("sim_c1_dack", d_ack_o, 1'b1);
    chk("sim_c1_addr", mem_addr_o, 32'h1000);
    tick();
    cyc(1, 32'h1000, 0, 0);
    chk("sim_c2_iack", i_ack_o, 1'b1);
    tick();
    // back-to-back ibus reads at 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'(4 * k), 0, 0);
      chk("b2b_grant", {i_ack_o, mem_req_o}, 2'b01);
      tick();
      cyc(1, 32'(4 * k), 0, 0);
      chk("b2b_ack", {i_ack_o, mem_req_o}, 2'b10);
      tick();
    end
    cyc(0, 0, 0, 0);
    tick();
    // continuous dbus stream with ibus held: ibus must still get served
    for (int k = 0; k < 24; k++) begin
      cyc(1, 32'h1000 + 32'(4 * (k / 2)), 1, 32'h2000 + 32'(4 * k));
      tick();
    end
    chk("stream_wait", max_wait <= MAXS + 1, 1'b1);
    // randomized traffic; each requester holds until acked
    for (int k = 0; k < 400; k++) begin
      logic ir, dr;
      logic [AW-1:0] iad, dad;
      ir = i_req_i; dr = d_req_i; iad = i_addr_i; dad = d_addr_i;
      if (!ir || ia) begin ir = $urandom_range(0, 2) != 0; iad = $urandom & ~32'h3; end
      if (!dr || da) begin dr = $urandom_range(0, 2) != 0; dad = $urandom & ~32'h3; end
      cyc(ir, iad, dr, dad);
      tick();
    end
    chk("rand_wait", max_wait <= MAXS + 1, 1'b1);
    // reset while a dbus read is pending drops the ack at once
    cyc(0, 0, 0, 0);
    tick();
    cyc(0, 0, 1, 32'h2000);
    chk("pre_rst_grant", mem_req_o, 1'b1);
    tick();
    i_req_i = 1'b1; i_addr_i = 32'h1000; d_req_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_dack", d_ack_o, 1'b0);
    chk("rst_mid_memreq", mem_req_o, 1'b0);
    chk("ack_count", n_ack + 1, n_req);
    pend = 0; streak = 0; i_wait = 0; n_req = 0; n_ack = 0;
    i_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h1000, 0, 0);
    chk("post_rst_noack", {i_ack_o, d_ack_o}, 2'b00);
    chk("post_rst_addr", mem_addr_o, 32'h1000);
    tick();
    cyc(1, 32'h1000, 0, 0);
    chk("post_rst_iack", i_ack_o, 1'b1);
    tick();
    cyc(0, 0, 0, 0);
    tick();
    chk("final_ack_count", n_ack, n_req);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
